// File: rtl/cs_seq_ctrl.sv
// cs_seq_ctrl: sequential compare-and-sort controller for three WIDTH-bit operands.
// A single greater-than comparator is shared across the A>B, A>C and B>C compares,
// one compare per cycle, building the select code {S2,S1,S0}. The code is then
// decoded into registered Max/Mid/Min values.
// Input and output each use a valid/ready handshake.
// Build option: define CS_SEQ_SIGNED_EN to compare operands as two's-complement signed
// values. By default operands are compared as unsigned values.
// Timing: a triple presented in the IDLE cycle that begins at edge t is captured at
// edge t+1. out_valid rises at edge t+4.

module cs_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Max,
  output logic [WIDTH-1:0] Mid,
  output logic [WIDTH-1:0] Min,
  output logic             busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMP_AB = 3'd1;
  localparam logic [2:0] CMP_AC = 3'd2;
  localparam logic [2:0] CMP_BC = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       stateQ, stateD;
  logic [2:0]       selQ;
  logic [WIDTH-1:0] regAQ, regBQ, regCQ;
  logic [WIDTH-1:0] maxQ, midQ, minQ;
  logic [WIDTH-1:0] opX, opY;
  logic             gt;
  logic [2:0]       finalSel;
  logic [WIDTH-1:0] maxD, midD, minD;

  // Handshake and status flags, all derived from the current state
  assign in_ready  = (stateQ == IDLE) && !rst;
  assign out_valid = (stateQ == DONE);
  assign busy      = (stateQ != IDLE);
  assign Max       = maxQ;
  assign Mid       = midQ;
  assign Min       = minQ;

  // Operand mux for the single shared comparator, steered by the compare state
  always_comb begin
    opX = regAQ;
    opY = regBQ;
    case (stateQ)
      CMP_AB: begin opX = regAQ; opY = regBQ; end
      CMP_AC: begin opX = regAQ; opY = regCQ; end
      CMP_BC: begin opX = regBQ; opY = regCQ; end
      default: begin opX = regAQ; opY = regBQ; end
    endcase
  end

`ifdef CS_SEQ_SIGNED_EN
  assign gt = ($signed(opX) > $signed(opY));
`else
  assign gt = (opX > opY);
`endif

  // S0 comes straight from the comparator so the decode can be registered on entry to DONE
  assign finalSel = {selQ[2], selQ[1], gt};

  // Select-code decode into Max/Mid/Min. Inconsistent codes 010 and 101 yield zero.
  always_comb begin
    maxD = '0;
    midD = '0;
    minD = '0;
    case (finalSel)
      3'b000: begin maxD = regCQ; midD = regBQ; minD = regAQ; end
      3'b001: begin maxD = regBQ; midD = regCQ; minD = regAQ; end
      3'b011: begin maxD = regBQ; midD = regAQ; minD = regCQ; end
      3'b100: begin maxD = regCQ; midD = regAQ; minD = regBQ; end
      3'b110: begin maxD = regAQ; midD = regCQ; minD = regBQ; end
      3'b111: begin maxD = regAQ; midD = regBQ; minD = regCQ; end
      default: begin maxD = '0; midD = '0; minD = '0; end
    endcase
  end

  // Next-state logic. DONE waits for out_ready before returning to IDLE.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (in_valid) stateD = CMP_AB;
      CMP_AB:  stateD = CMP_AC;
      CMP_AC:  stateD = CMP_BC;
      CMP_BC:  stateD = DONE;
      DONE:    if (out_ready) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // State register, operand capture, select bits and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
      selQ   <= 3'b000;
      regAQ  <= '0;
      regBQ  <= '0;
      regCQ  <= '0;
      maxQ   <= '0;
      midQ   <= '0;
      minQ   <= '0;
    end else begin
      stateQ <= stateD;
      case (stateQ)
        IDLE: begin
          if (in_valid) begin
            regAQ <= A;
            regBQ <= B;
            regCQ <= C;
          end
        end
        CMP_AB: selQ[2] <= gt;
        CMP_AC: selQ[1] <= gt;
        CMP_BC: begin
          selQ[0] <= gt;
          maxQ    <= maxD;
          midQ    <= midD;
          minQ    <= minD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_seq_ctrl.sv
// tb_cs_seq_ctrl: scoreboard bench for cs_seq_ctrl.
// For each driven triple, the expected sorted values are pushed onto a queue.
// They are popped and compared when out_valid appears.
// The reference sort follows CS_SEQ_SIGNED_EN in the same way as the design.

module tb_cs_seq_ctrl;

  typedef struct packed {
    logic [7:0] mx;
    logic [7:0] md;
    logic [7:0] mn;
  } trip_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B, C;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Max, Mid, Min;
  logic       busy;

  int    checkCount;
  int    failCount;
  trip_t expQ[$];

  cs_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Max       (Max),
    .Mid       (Mid),
    .Min       (Min),
    .busy      (busy)
  );

  // Free-running clock with a 10-time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its expected value and counts the comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference greater-than, matching the build option
  function automatic logic refGt(input logic [7:0] x, input logic [7:0] y);
`ifdef CS_SEQ_SIGNED_EN
    return $signed(x) > $signed(y);
`else
    return x > y;
`endif
  endfunction

  // Reference sort of three values into max/mid/min
  function automatic trip_t refSort(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] c);
    logic [7:0] v[3];
    logic [7:0] t;
    trip_t      r;
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (refGt(v[j], v[j+1])) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    r.mn = v[0];
    r.md = v[1];
    r.mx = v[2];
    return r;
  endfunction

  // Drives one triple, waits for the result, checks latency and values,
  // then optionally applies backpressure for holdCycles cycles
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input int holdCycles);
    trip_t exp;
    trip_t got;
    int    cycles;
    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 1);
    out_ready = (holdCycles == 0);
    in_valid  = 1'b1;
    A = a; B = b; C = c;
    expQ.push_back(refSort(a, b, c));
    @(negedge clk);
    in_valid = 1'b0;
    A = 8'h00; B = 8'h00; C = 8'h00;
    checkOutput("busy_after_accept", busy, 1);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", cycles, 3);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
      return;
    end
    exp = expQ.pop_front();
    got = '{mx: Max, md: Mid, mn: Min};
    checkOutput("Max", got.mx, exp.mx);
    checkOutput("Mid", got.md, exp.md);
    checkOutput("Min", got.mn, exp.mn);
    if (holdCycles > 0) begin
      for (int k = 0; k < holdCycles; k++) begin
        in_valid = 1'b1;
        A = 8'h01; B = 8'h02; C = 8'h03;
        @(negedge clk);
        checkOutput("hold_out_valid", out_valid, 1);
        checkOutput("hold_in_ready", in_ready, 0);
        checkOutput("hold_Max", Max, exp.mx);
        checkOutput("hold_Mid", Mid, exp.md);
        checkOutput("hold_Min", Min, exp.mn);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("release_out_valid", out_valid, 0);
    checkOutput("release_busy", busy, 0);
    checkOutput("release_in_ready", in_ready, 1);
    checkOutput("retain_Max", Max, exp.mx);
    checkOutput("retain_Min", Min, exp.mn);
  endtask

  // Main sequence: reset, basic sort, permutations, ties, backpressure,
  // signed-sensitive values, a random sweep, and reset in the middle of an operation
  initial begin
    logic [7:0] perm[6][3];
    trip_t      dropped;
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = 8'h00; B = 8'h00; C = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_Max", Max, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);

    applyStimulus(8'd6, 8'd48, 8'd25, 0);

    perm = '{'{8'd10, 8'd20, 8'd30}, '{8'd10, 8'd30, 8'd20}, '{8'd20, 8'd10, 8'd30},
             '{8'd20, 8'd30, 8'd10}, '{8'd30, 8'd10, 8'd20}, '{8'd30, 8'd20, 8'd10}};
    for (int p = 0; p < 6; p++) applyStimulus(perm[p][0], perm[p][1], perm[p][2], 0);

    applyStimulus(8'd7, 8'd7, 8'd7, 0);
    applyStimulus(8'd9, 8'd9, 8'd3, 0);
    applyStimulus(8'd3, 8'd9, 8'd9, 0);

    applyStimulus(8'd100, 8'd5, 8'd60, 5);

    applyStimulus(8'hFF, 8'h01, 8'h80, 0);
`ifdef CS_SEQ_SIGNED_EN
    checkOutput("signed_Max", Max, 8'h01);
    checkOutput("signed_Mid", Mid, 8'hFF);
    checkOutput("signed_Min", Min, 8'h80);
`else
    checkOutput("unsigned_Max", Max, 8'hFF);
    checkOutput("unsigned_Mid", Mid, 8'h80);
    checkOutput("unsigned_Min", Min, 8'h01);
`endif

    for (int r = 0; r < 8; r++)
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));

    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    A = 8'd1; B = 8'd2; C = 8'd3;
    expQ.push_back(refSort(8'd1, 8'd2, 8'd3));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_Max", Max, 0);
    checkOutput("midrst_Mid", Mid, 0);
    checkOutput("midrst_Min", Min, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    if (expQ.size() > 0) dropped = expQ.pop_front();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_release_in_ready", in_ready, 1);
    checkOutput("midrst_no_output", out_valid, 0);

    applyStimulus(8'd6, 8'd48, 8'd25, 0);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
